regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin arbiter sharing one regfile write port between
//               an ALU writeback (A) and a load writeback (B). Grants at
//               most one write per cycle into a single output register and
//               counts contention cycles with a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [63:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [63:0] b_data,
    output logic        b_ready,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [63:0] wd3,
    output logic [31:0] pend,
    output logic [15:0] conflicts
);

    // X31 is the zero register: writes are acknowledged but never performed
    localparam logic [4:0]  XZR_ADDR      = 5'd31;
    localparam logic [15:0] CONFLICTS_MAX = 16'hFFFF;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    prio_t       prio_q, prio_d;
    logic        we3_q, we3_d;
    logic [4:0]  wa3_q, wa3_d;
    logic [63:0] wd3_q, wd3_d;
    logic [15:0] conflicts_q, conflicts_d;

    logic        grant_a;
    logic        grant_b;

    // Grant decision: depends only on valids, priority and reset, never on addr/data
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            grant_a = a_valid && (!b_valid || (prio_q == PRIO_A));
            grant_b = b_valid && (!a_valid || (prio_q == PRIO_B));
        end
    end

    // Next-state for priority, output stage and contention counter
    always_comb begin
        prio_d      = prio_q;
        we3_d       = 1'b0;
        wa3_d       = wa3_q;
        wd3_d       = wd3_q;
        conflicts_d = conflicts_q;

        if (grant_a) begin
            prio_d = PRIO_B;
            we3_d  = (a_addr != XZR_ADDR);
            wa3_d  = a_addr;
            wd3_d  = a_data;
        end else if (grant_b) begin
            prio_d = PRIO_A;
            we3_d  = (b_addr != XZR_ADDR);
            wa3_d  = b_addr;
            wd3_d  = b_data;
        end

        if (a_valid && b_valid && (conflicts_q != CONFLICTS_MAX)) begin
            conflicts_d = conflicts_q + 16'd1;
        end
    end

    // State register with synchronous reset; reset discards any staged write
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q      <= PRIO_A;
            we3_q       <= 1'b0;
            wa3_q       <= 5'd0;
            wd3_q       <= 64'd0;
            conflicts_q <= 16'd0;
        end else begin
            prio_q      <= prio_d;
            we3_q       <= we3_d;
            wa3_q       <= wa3_d;
            wd3_q       <= wd3_d;
            conflicts_q <= conflicts_d;
        end
    end

    // Output decode; we3 is never set for X31, so pend bit 31 stays clear
    always_comb begin
        a_ready   = grant_a;
        b_ready   = grant_b;
        we3       = we3_q;
        wa3       = wa3_q;
        wd3       = wd3_q;
        conflicts = conflicts_q;
        pend      = we3_q ? (32'h1 << wa3_q) : 32'h0;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter with a
//               behavioural model of arbitration, output stage and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr;
    logic [63:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        we3;
    logic [4:0]  wa3;
    logic [63:0] wd3;
    logic [31:0] pend;
    logic [15:0] conflicts;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_a_turn;   // 1: A wins a tie
    int          m_conf;
    bit          m_we;
    logic [4:0]  m_wa;
    logic [63:0] m_wd;
    bit          m_known;    // wa3/wd3 content is well defined by the model
    bit          last_ga, last_gb;

    regfile_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .we3(we3), .wa3(wa3), .wd3(wd3), .pend(pend), .conflicts(conflicts)
    );

    always #5 clk = ~clk;

    function automatic bit exp_a_ready();
        return !reset && a_valid && (!b_valid || m_a_turn);
    endfunction

    function automatic bit exp_b_ready();
        return !reset && b_valid && (!a_valid || !m_a_turn);
    endfunction

    function automatic logic [31:0] exp_pend();
        logic [31:0] one = 32'h1;
        return m_we ? (one << m_wa) : 32'h0;
    endfunction

    // Advance one clock edge and update the model from the pre-edge inputs
    task automatic tick();
        bit ga, gb;
        ga = exp_a_ready();
        gb = exp_b_ready();
        @(posedge clk);
        last_ga = ga;
        last_gb = gb;
        if (reset) begin
            m_we = 0; m_wa = 0; m_wd = 0; m_known = 1; m_a_turn = 1; m_conf = 0;
        end else begin
            if (a_valid && b_valid && m_conf < 65535) m_conf++;
            if (ga || gb) begin
                logic [4:0]  ad;
                logic [63:0] dd;
                ad = ga ? a_addr : b_addr;
                dd = ga ? a_data : b_data;
                m_we = (ad != 5'd31);
                if (m_we) begin m_wa = ad; m_wd = dd; m_known = 1; end
                else m_known = 0;
                m_a_turn = gb;
            end else begin
                m_we = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0;
        a_addr = 0; b_addr = 0;
        a_data = 0; b_data = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        a_valid = 1; b_valid = 1; a_addr = 4; b_addr = 6;
        #1;
        n_checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: a_ready=%b b_ready=%b expected 0 0", a_ready, b_ready);
        end
        tick();
        n_checks++;
        if (we3 !== 1'b0 || wa3 !== 5'd0 || wd3 !== 64'd0 || pend !== 32'h0 || conflicts !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: we3=%b wa3=%0d wd3=%h pend=%h conflicts=%0d expected all zero",
                     we3, wa3, wd3, pend, conflicts);
        end
        reset = 0;
        idle_inputs();
        tick();
    endtask

    task automatic test_single_a();
        a_valid = 1; a_addr = 5; a_data = 64'hDEAD;
        #1;
        n_checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_fail++; $display("FAIL single_a_ready: a_ready=%b b_ready=%b expected 1 0", a_ready, b_ready);
        end
        tick();
        a_valid = 0;
        n_checks++;
        if (we3 !== 1'b1 || wa3 !== 5'd5 || wd3 !== 64'hDEAD || pend !== 32'h20) begin
            n_fail++;
            $display("FAIL single_a_write: we3=%b wa3=%0d wd3=%h pend=%h expected 1 5 dead 00000020",
                     we3, wa3, wd3, pend);
        end
        tick();
        n_checks++;
        if (we3 !== 1'b0 || wa3 !== 5'd5 || wd3 !== 64'hDEAD || pend !== 32'h0) begin
            n_fail++;
            $display("FAIL single_a_drain: we3=%b wa3=%0d wd3=%h pend=%h expected 0 5 dead 0",
                     we3, wa3, wd3, pend);
        end
    endtask

    task automatic test_contention();
        do_reset();
        a_valid = 1; a_addr = 3; a_data = 64'd1;
        b_valid = 1; b_addr = 3; b_data = 64'd2;
        #1;
        n_checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_fail++; $display("FAIL contention_grant0: a_ready=%b b_ready=%b expected 1 0", a_ready, b_ready);
        end
        tick();
        a_valid = 0;
        #1;
        n_checks++;
        if (we3 !== 1'b1 || wa3 !== 5'd3 || wd3 !== 64'd1 || conflicts !== 16'd1 || b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL contention_first: we3=%b wa3=%0d wd3=%0d conflicts=%0d b_ready=%b expected 1 3 1 1 1",
                     we3, wa3, wd3, conflicts, b_ready);
        end
        tick();
        b_valid = 0;
        n_checks++;
        if (we3 !== 1'b1 || wa3 !== 5'd3 || wd3 !== 64'd2 || conflicts !== 16'd1) begin
            n_fail++;
            $display("FAIL contention_second: we3=%b wa3=%0d wd3=%0d conflicts=%0d expected 1 3 2 1",
                     we3, wa3, wd3, conflicts);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int cnt_a = 0, cnt_b = 0;
        logic [63:0] exp_wd;
        do_reset();
        a_valid = 1; b_valid = 1;
        a_addr = 5'($urandom_range(0, 30)); a_data = {$urandom, $urandom};
        b_addr = 5'($urandom_range(0, 30)); b_data = {$urandom, $urandom};
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if (a_ready !== ((i % 2) == 0) || b_ready !== ((i % 2) == 1)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: a_ready=%b b_ready=%b expected %b %b",
                         i, a_ready, b_ready, (i % 2) == 0, (i % 2) == 1);
            end
            exp_wd = ((i % 2) == 0) ? a_data : b_data;
            tick();
            if (last_ga) cnt_a++;
            if (last_gb) cnt_b++;
            n_checks++;
            if (we3 !== 1'b1 || wd3 !== exp_wd) begin
                n_fail++; $display("FAIL rr_data[%0d]: we3=%b wd3=%h expected 1 %h", i, we3, wd3, exp_wd);
            end
            if (last_ga) begin a_addr = 5'($urandom_range(0, 30)); a_data = {$urandom, $urandom}; end
            if (last_gb) begin b_addr = 5'($urandom_range(0, 30)); b_data = {$urandom, $urandom}; end
        end
        idle_inputs();
        n_checks++;
        if (cnt_a != 5 || cnt_b != 5 || conflicts !== 16'd10) begin
            n_fail++;
            $display("FAIL rr_totals: grants_a=%0d grants_b=%0d conflicts=%0d expected 5 5 10", cnt_a, cnt_b, conflicts);
        end
        tick();
    endtask

    task automatic test_xzr();
        b_valid = 1; b_addr = 5'd31; b_data = 64'h55;
        #1;
        n_checks++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            n_fail++; $display("FAIL xzr_ready: b_ready=%b a_ready=%b expected 1 0", b_ready, a_ready);
        end
        tick();
        b_valid = 0;
        n_checks++;
        if (we3 !== 1'b0 || pend !== 32'h0) begin
            n_fail++; $display("FAIL xzr_write: we3=%b pend=%h expected 0 0", we3, pend);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        a_valid = 1; a_addr = 7; a_data = {$urandom, $urandom};
        tick();
        a_valid = 1; b_valid = 1; b_addr = 9; b_data = 64'h9;
        reset = 1;
        #1;
        n_checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_ready: a_ready=%b b_ready=%b expected 0 0", a_ready, b_ready);
        end
        tick();
        reset = 0;
        n_checks++;
        if (we3 !== 1'b0 || conflicts !== 16'd0 || pend !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_state: we3=%b conflicts=%0d pend=%h expected 0 0 0", we3, conflicts, pend);
        end
        #1;
        n_checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_prio: a_ready=%b b_ready=%b expected 1 0", a_ready, b_ready);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            // A losing requester keeps its request stable; others are re-rolled
            if (!(a_valid && !last_ga) || reset) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_addr  = 5'($urandom);
                a_data  = {$urandom, $urandom};
            end
            if (!(b_valid && !last_gb) || reset) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_addr  = 5'($urandom);
                b_data  = {$urandom, $urandom};
            end
            reset = ($urandom_range(0, 39) == 0);
            #1;
            n_checks++;
            if (a_ready !== exp_a_ready() || b_ready !== exp_b_ready()) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: a_ready=%b b_ready=%b expected %b %b",
                         i, a_ready, b_ready, exp_a_ready(), exp_b_ready());
            end
            tick();
            n_checks++;
            if (we3 !== m_we || pend !== exp_pend() || conflicts !== 16'(m_conf) ||
                (m_known && (wa3 !== m_wa || wd3 !== m_wd))) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: we3=%b wa3=%0d wd3=%h pend=%h conf=%0d expected %b %0d %h %h %0d",
                         i, we3, wa3, wd3, pend, conflicts, m_we, m_wa, m_wd, exp_pend(), m_conf);
            end
        end
        reset = 0;
        idle_inputs();
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        a_valid = 1; b_valid = 1; a_addr = 1; b_addr = 2;
        for (int i = 1; i <= 65540; i++) begin
            a_data = 64'(i);
            b_data = 64'(i);
            tick();
            if (i == 65534 || i == 65535 || i == 65540) begin
                n_checks++;
                if (conflicts !== 16'(m_conf) || conflicts !== ((i < 65535) ? 16'(i) : 16'hFFFF)) begin
                    n_fail++;
                    $display("FAIL saturation[%0d]: conflicts=%h expected %h", i, conflicts,
                             (i < 65535) ? 16'(i) : 16'hFFFF);
                end
            end
        end
        idle_inputs();
        tick();
        n_checks++;
        if (conflicts !== 16'hFFFF) begin
            n_fail++; $display("FAIL saturation_hold: conflicts=%h expected ffff", conflicts);
        end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        m_a_turn = 1; m_conf = 0; m_we = 0; m_wa = 0; m_wd = 0; m_known = 1;
        last_ga = 0; last_gb = 0;
        test_reset();
        test_single_a();
        test_contention();
        test_round_robin();
        test_xzr();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
